// File: rtl/ascon_phase_ctrl.sv
// Ascon AEAD phase sequencer: steps through init, AD, domain separation, PT/CT,
// finalization and tag, launching the shared permutation core and issuing state strobes.
module ascon_phase_ctrl #(
    parameter int unsigned k = 128,
    parameter int unsigned r = 128,
    parameter int unsigned a = 12,
    parameter int unsigned b = 6,
    parameter int unsigned l = 80,
    parameter int unsigned y = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       encryption_startxSI,
    input  logic       decryption_startxSI,
    input  logic       perm_readyxSI,
    output logic       perm_startxSO,
    output logic [3:0] perm_roundsxSO,
    output logic       load_statexSO,
    output logic       key_xorxSO,
    output logic       ad_absorbxSO,
    output logic       domsepxSO,
    output logic       pt_absorbxSO,
    output logic       fin_keyxSO,
    output logic       tag_capturexSO,
    output logic [7:0] blk_idxxSO,
    output logic       decxSO,
    output logic       busyxSO,
    output logic       encryption_readyxSO,
    output logic       decryption_readyxSO
);

    localparam int unsigned NAD = (l == 0) ? 0 : l / r + 1;
    localparam int unsigned NPT = y / r + 1;
    localparam bit          HAS_AD  = (NAD != 0);
    localparam logic [7:0]  AD_LAST = HAS_AD ? 8'(NAD - 1) : 8'd0;
    localparam logic [7:0]  PT_LAST = 8'(NPT - 1);
    localparam logic [3:0]  ROUNDS_A = 4'(a);
    localparam logic [3:0]  ROUNDS_B = 4'(b);

    if (k == 0 || r == 0 || a == 0 || a > 15 || b == 0 || b > 15) begin : g_param_check
        $error("ascon_phase_ctrl: invalid parameter set");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_INIT_PERM,
        S_INIT_KEY,
        S_AD_ABS,
        S_AD_PERM,
        S_DOMSEP,
        S_PT_ABS,
        S_PT_PERM,
        S_FIN_KEY,
        S_FIN_PERM,
        S_TAG,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] w_blk_nxt;
    logic       w_dec_nxt;
    logic       w_perm_done;
    logic       w_nxt_is_perm;
    logic [3:0] w_rounds_nxt;

    // The start pulse is high exactly in the first cycle of a wait state, so a
    // ready coinciding with it is masked out.
    assign w_perm_done = perm_readyxSI & ~perm_startxSO;

    always_comb begin
        w_state_nxt = r_state;
        w_blk_nxt   = blk_idxxSO;
        w_dec_nxt   = decxSO;
        case (r_state)
            S_IDLE: begin
                if (encryption_startxSI || decryption_startxSI) begin
                    w_state_nxt = S_LOAD;
                    w_dec_nxt   = ~encryption_startxSI;
                    w_blk_nxt   = '0;
                end
            end
            S_LOAD:      w_state_nxt = S_INIT_PERM;
            S_INIT_PERM: if (w_perm_done) w_state_nxt = S_INIT_KEY;
            S_INIT_KEY:  w_state_nxt = HAS_AD ? S_AD_ABS : S_DOMSEP;
            S_AD_ABS:    w_state_nxt = S_AD_PERM;
            S_AD_PERM: begin
                if (w_perm_done) begin
                    if (blk_idxxSO < AD_LAST) begin
                        w_blk_nxt   = blk_idxxSO + 8'd1;
                        w_state_nxt = S_AD_ABS;
                    end else begin
                        w_blk_nxt   = '0;
                        w_state_nxt = S_DOMSEP;
                    end
                end
            end
            S_DOMSEP:    w_state_nxt = S_PT_ABS;
            S_PT_ABS:    w_state_nxt = (blk_idxxSO < PT_LAST) ? S_PT_PERM : S_FIN_KEY;
            S_PT_PERM: begin
                if (w_perm_done) begin
                    w_blk_nxt   = blk_idxxSO + 8'd1;
                    w_state_nxt = S_PT_ABS;
                end
            end
            S_FIN_KEY:   w_state_nxt = S_FIN_PERM;
            S_FIN_PERM:  if (w_perm_done) w_state_nxt = S_TAG;
            S_TAG:       w_state_nxt = S_DONE;
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_blk_nxt   = '0;
            end
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_nxt_is_perm = 1'b0;
        w_rounds_nxt  = '0;
        case (w_state_nxt)
            S_INIT_PERM, S_FIN_PERM: begin
                w_nxt_is_perm = 1'b1;
                w_rounds_nxt  = ROUNDS_A;
            end
            S_AD_PERM, S_PT_PERM: begin
                w_nxt_is_perm = 1'b1;
                w_rounds_nxt  = ROUNDS_B;
            end
            default: begin
                w_nxt_is_perm = 1'b0;
                w_rounds_nxt  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so each one is a flop aligned with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= S_IDLE;
            perm_startxSO       <= 1'b0;
            perm_roundsxSO      <= '0;
            load_statexSO       <= 1'b0;
            key_xorxSO          <= 1'b0;
            ad_absorbxSO        <= 1'b0;
            domsepxSO           <= 1'b0;
            pt_absorbxSO        <= 1'b0;
            fin_keyxSO          <= 1'b0;
            tag_capturexSO      <= 1'b0;
            blk_idxxSO          <= '0;
            decxSO              <= 1'b0;
            busyxSO             <= 1'b0;
            encryption_readyxSO <= 1'b0;
            decryption_readyxSO <= 1'b0;
        end else begin
            r_state             <= w_state_nxt;
            perm_startxSO       <= w_nxt_is_perm && (w_state_nxt != r_state);
            perm_roundsxSO      <= w_rounds_nxt;
            load_statexSO       <= (w_state_nxt == S_LOAD);
            key_xorxSO          <= (w_state_nxt == S_INIT_KEY);
            ad_absorbxSO        <= (w_state_nxt == S_AD_ABS);
            domsepxSO           <= (w_state_nxt == S_DOMSEP);
            pt_absorbxSO        <= (w_state_nxt == S_PT_ABS);
            fin_keyxSO          <= (w_state_nxt == S_FIN_KEY);
            tag_capturexSO      <= (w_state_nxt == S_TAG);
            blk_idxxSO          <= w_blk_nxt;
            decxSO              <= w_dec_nxt;
            busyxSO             <= (w_state_nxt != S_IDLE);
            encryption_readyxSO <= (w_state_nxt == S_DONE) && !w_dec_nxt;
            decryption_readyxSO <= (w_state_nxt == S_DONE) && w_dec_nxt;
        end
    end

endmodule
